// File: rtl/scs8hd_reqfilt_4.sv
// Request filter: ORs four mixed-polarity asynchronous requests, synchronizes them,
// debounces the level and hands a single qualified event to the consumer.
module scs8hd_reqfilt_4 #(
  parameter int DBNC_CYC = 3
) (
`ifdef SC_USE_PG_PIN
  input  logic       vpwr,
  input  logic       vgnd,
  input  logic       vpb,
  input  logic       vnb,
`endif
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A,
  input  logic       B,
  input  logic       CN,
  input  logic       DN,
  input  logic       ACK,
  output logic       X,
  output logic       XPULSE,
  output logic       BUSY,
  output logic [7:0] EVCNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUAL     = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(DBNC_CYC - 1);

  logic   w_pg_ok;
  logic   w_raw;
  logic   r_s1_p0;
  logic   r_s2_p1;
  state_t r_state;
  state_t w_nxt_state;
  logic [3:0] r_cnt;
  logic [3:0] w_nxt_cnt;
  logic   w_enter_act;
  logic   r_x;
  logic   r_xpulse;
  logic   r_busy;
  logic [7:0] r_evcnt;

`ifdef SC_USE_PG_PIN
  assign w_pg_ok = vpwr & vpb & ~vgnd & ~vnb;
`elsif FUNCTIONAL
  assign w_pg_ok = 1'b1;
`else
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
  assign w_pg_ok = vpwr & vpb & ~vgnd & ~vnb;
`endif

  assign w_raw = w_pg_ok & (A | B | ~CN | ~DN);

  // Stage p0/p1: two-flop synchronizer; only r_s2_p1 is seen by the FSM
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1_p0 <= 1'b0;
      r_s2_p1 <= 1'b0;
    end else begin
      r_s1_p0 <= w_raw;
      r_s2_p1 <= r_s1_p0;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_s2_p1) begin
          w_nxt_state = ST_QUAL;
          w_nxt_cnt   = 4'd1;
        end
      end
      ST_QUAL: begin
        if (!r_s2_p1) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = 4'd0;
        end else if (r_cnt == LP_LAST) begin
          w_nxt_state = ST_ACTIVE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt   = r_cnt + 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (ACK) begin
          w_nxt_state = ST_WAIT_LOW;
          w_nxt_cnt   = 4'd0;
        end
      end
      ST_WAIT_LOW: begin
        // Any high sample restarts the release count, so a held request cannot re-fire
        if (r_s2_p1) begin
          w_nxt_cnt   = 4'd0;
        end else if (r_cnt == LP_LAST) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  assign w_enter_act = (r_state != ST_ACTIVE) && (w_nxt_state == ST_ACTIVE);

  // Stage p2: FSM state and registered outputs decoded from the next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_x      <= 1'b0;
      r_xpulse <= 1'b0;
      r_busy   <= 1'b0;
      r_evcnt  <= 8'd0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_x      <= (w_nxt_state == ST_ACTIVE);
      r_xpulse <= w_enter_act;
      r_busy   <= (w_nxt_state != ST_IDLE);
      if (w_enter_act && (r_evcnt != 8'hFF)) begin
        r_evcnt <= r_evcnt + 8'd1;
      end
    end
  end

  assign X      = r_x;
  assign XPULSE = r_xpulse;
  assign BUSY   = r_busy;
  assign EVCNT  = r_evcnt;

endmodule

// File: tb/tb_scs8hd_reqfilt_4.sv
// Directed bench for scs8hd_reqfilt_4 (DBNC_CYC=3): per-edge vector table plus
// hand-written reset-in-ACTIVE, idle-polarity and counter-saturation sequences.
module tb_scs8hd_reqfilt_4;

  logic       CLK = 1'b0;
  logic       RESET, A, B, CN, DN, ACK;
  logic       X, XPULSE, BUSY;
  logic [7:0] EVCNT;

  int n_chk = 0;
  int n_err = 0;

  scs8hd_reqfilt_4 #(.DBNC_CYC(3)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .A      (A),
    .B      (B),
    .CN     (CN),
    .DN     (DN),
    .ACK    (ACK),
    .X      (X),
    .XPULSE (XPULSE),
    .BUSY   (BUSY),
    .EVCNT  (EVCNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, a, b, cn, dn, ack;
    logic       x, xp, busy;
    logic [7:0] ev;
  } vec_t;

  localparam int NV = 36;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rst, input logic a, input logic b,
                              input logic cn, input logic dn, input logic ack,
                              input logic x, input logic xp, input logic busy,
                              input logic [7:0] ev);
    vec_t v;
    v.rst = rst; v.a = a; v.b = b; v.cn = cn; v.dn = dn; v.ack = ack;
    v.x = x; v.xp = xp; v.busy = busy; v.ev = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic a, input logic b,
                       input logic cn, input logic dn, input logic ack);
    RESET = rst; A = a; B = b; CN = cn; DN = dn; ACK = ack;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int  k;
  logic [7:0] exp_ev;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    //            rst a  b  cn dn ack   x  xp busy ev
    vt[0]  = mk(1, 1, 0, 1, 1, 0,   0, 0, 0, 0);
    vt[1]  = mk(1, 1, 0, 1, 1, 0,   0, 0, 0, 0);
    vt[2]  = mk(0, 1, 0, 1, 1, 0,   0, 0, 0, 0);
    vt[3]  = mk(0, 1, 0, 1, 1, 0,   0, 0, 0, 0);
    vt[4]  = mk(0, 1, 0, 1, 1, 0,   0, 0, 1, 0);
    vt[5]  = mk(0, 1, 0, 1, 1, 0,   0, 0, 1, 0);
    vt[6]  = mk(0, 1, 0, 1, 1, 0,   1, 1, 1, 1);
    vt[7]  = mk(0, 1, 0, 1, 1, 0,   1, 0, 1, 1);
    vt[8]  = mk(0, 1, 0, 1, 1, 1,   0, 0, 1, 1);
    vt[9]  = mk(0, 1, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[10] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[11] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[12] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[13] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[14] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vt[15] = mk(0, 0, 0, 1, 1, 1,   0, 0, 0, 1);
    vt[16] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
    vt[17] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
    vt[18] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[19] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vt[20] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vt[21] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vt[22] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vt[23] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vt[24] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
    vt[25] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
    vt[26] = mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 1);
    vt[27] = mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 1);
    vt[28] = mk(0, 0, 0, 1, 0, 1,   1, 1, 1, 2);
    vt[29] = mk(0, 0, 0, 1, 0, 0,   1, 0, 1, 2);
    vt[30] = mk(0, 0, 0, 1, 0, 1,   0, 0, 1, 2);
    vt[31] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 2);
    vt[32] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 2);
    vt[33] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 2);
    vt[34] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 2);
    vt[35] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 2);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].a, vt[i].b, vt[i].cn, vt[i].dn, vt[i].ack);
      step();
      chk("vec_x",     i, {7'd0, X},      {7'd0, vt[i].x});
      chk("vec_xpulse", i, {7'd0, XPULSE}, {7'd0, vt[i].xp});
      chk("vec_busy",  i, {7'd0, BUSY},   {7'd0, vt[i].busy});
      chk("vec_evcnt", i, EVCNT,          vt[i].ev);
    end

    // All inputs at their inactive levels for 20 cycles: nothing may happen
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_x",    i, {7'd0, X},    8'd0);
      chk("idle_busy", i, {7'd0, BUSY}, 8'd0);
    end
    chk("idle_evcnt", 0, EVCNT, 8'd2);

    // Reset while ACTIVE with ACK on the same edge, request still held
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    k = 0;
    while (k < 12 && X !== 1'b1) begin
      step();
      k++;
    end
    chk("midact_x_up", k, {7'd0, X}, 8'd1);
    chk("midact_ev_pre", k, EVCNT, 8'd3);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("midact_rst_x",    0, {7'd0, X},      8'd0);
    chk("midact_rst_xp",   0, {7'd0, XPULSE}, 8'd0);
    chk("midact_rst_busy", 0, {7'd0, BUSY},   8'd0);
    chk("midact_rst_ev",   0, EVCNT,          8'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("requal_x", e, {7'd0, X}, (e == 5) ? 8'd1 : 8'd0);
    end
    chk("requal_ev", 0, EVCNT, 8'd1);

    // Saturation: 300 complete request/ACK/release cycles starting from zero
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("sat_rst_ev", 0, EVCNT, 8'd0);
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      k = 0;
      while (k < 12 && XPULSE !== 1'b1) begin
        step();
        k++;
      end
      chk("sat_pulse", i, {7'd0, XPULSE}, 8'd1);
      exp_ev = (i > 255) ? 8'd255 : 8'(i);
      chk("sat_evcnt", i, EVCNT, exp_ev);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      k = 0;
      while (k < 12 && BUSY !== 1'b0) begin
        step();
        k++;
      end
      chk("sat_release", i, {7'd0, BUSY}, 8'd0);
    end
    chk("sat_final", 0, EVCNT, 8'd255);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
